pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline. It produces all per-stage stall and flush controls and the E-stage operand forwarding selects. It detects load-use hazards and taken-branch flushes, and runs a multi-cycle data-memory req/ack handshake with timeout for the M stage. It also keeps a saturating stall-cycle counter and a sticky memory-error flag.

Parameters:
MEM_TIMEOUT, 16, max request cycles per memory access before abort (>=2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  reset
rs1_addr_D  in  5  D-stage source reg 1
rs2_addr_D  in  5  D-stage source reg 2
rs1_addr_E  in  5  E-stage source reg 1
rs2_addr_E  in  5  E-stage source reg 2
rd_E  in  5  E-stage destination
reg_write_E  in  1  E-stage writes rd (0 for bubbles)
sel_wb_E  in  2  E-stage writeback select; 2'b00 = load
rd_M  in  5  M-stage destination
reg_write_M  in  1  M-stage writes rd
rd_W  in  5  W-stage destination
reg_write_W  in  1  W-stage writes rd
pc_src_E  in  1  branch/jump taken in E
mem_access_M  in  1  load or store in M
dmem_ack  in  1  data memory completes access this cycle
dmem_req  out  1  data memory request
stallF, stallD, stallE, stallM  out  1 each  hold stage register
flushD, flushE, flushW  out  1 each  bubble stage register
forwardA_E, forwardB_E  out  2 each  00 regfile, 01 from W, 10 from M
stall_cycles  out  CNT_W  cycles with stallF=1, saturating
mem_err  out  1  sticky, memory access timed out

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high.
- Reset: state=IDLE, wait_cnt=0, stall_cycles=0, mem_err=0. While rst=1, all stall/flush/dmem_req outputs are 0 and forward selects are 00.
- Memory FSM, states IDLE and WAIT; wait_cnt counts request cycles:
  - dmem_req = (IDLE & mem_access_M) | WAIT.
  - mem_stall = dmem_req & !dmem_ack & !timeout.
  - timeout = WAIT & (wait_cnt == MEM_TIMEOUT-1) & !dmem_ack.
- FSM transitions:
  - IDLE & mem_access_M & !dmem_ack -> WAIT, wait_cnt<=1.
  - IDLE & mem_access_M & dmem_ack: zero-wait access, no stall, stay in IDLE.
  - WAIT & dmem_ack -> IDLE, wait_cnt<=0. Ack wins over a simultaneous timeout.
  - WAIT & timeout -> IDLE, mem_err<=1, stall released that cycle.
  - Otherwise in WAIT, wait_cnt++.
- Load-use hazard: lu = reg_write_E & (sel_wb_E==00) & (rd_E!=0) & ((rd_E==rs1_addr_D)|(rd_E==rs2_addr_D)). Exactly 1 cycle of stall.
- Output priority, highest first:
  1. mem_stall: stallF=stallD=stallE=stallM=1, flushW=1. flushD=flushE=0; branch and load-use are suppressed and re-evaluated after release.
  2. pc_src_E: flushD=flushE=1, stallF=stallD=0. The branch overrides load-use because the D instruction is discarded.
  3. lu: stallF=stallD=1, flushE=1.
  4. Otherwise all stall/flush outputs are 0.
- Forwarding, combinational, evaluated for A with rs1_addr_E and for B with rs2_addr_E:
  - 10 if reg_write_M & rd_M!=0 & rd_M==rs.
  - else 01 if reg_write_W & rd_W!=0 & rd_W==rs.
  - else 00.
  - M takes priority over W.
- stall_cycles increments on each clock edge where stallF=1 and rst=0, and saturates at all-ones.
- mem_err is cleared only by rst.
- Reset during WAIT: next edge goes to IDLE. dmem_req is 0 during the rst cycle and after it unless mem_access_M is asserted.

Test Plan:
1. Load-use: reg_write_E=1, sel_wb_E=00, rd_E=5, rs1_addr_D=5 -> stallF=stallD=flushE=1 for one cycle, stall_cycles=1. Repeating with rd_E=0 -> all stalls 0.
2. Branch vs load-use: case 1 plus pc_src_E=1 -> flushD=flushE=1, stallF=stallD=0.
3. Forwarding: rs1_addr_E=7, rd_M=7, reg_write_M=1, rd_W=7, reg_write_W=1 -> forwardA_E=10. With reg_write_M=0 -> 01. With rd_W=0 as well -> 00. Repeat the same checks for forwardB_E using rs2_addr_E.
4. Memory wait: mem_access_M=1 at cycle 0, dmem_ack=1 at cycle 3 -> dmem_req=1 on cycles 0-3; stallF/D/E/M=1 and flushW=1 on cycles 0-2, released on cycle 3; stall_cycles=3. Also assert pc_src_E during cycles 0-2 -> flushD=flushE=0 throughout.
5. Timeout: MEM_TIMEOUT=8, no ack -> dmem_req=1 for 8 cycles, stall for 7 cycles, mem_err=1 from cycle 8 and held. Ack on cycle 7 -> mem_err stays 0.
6. Reset mid-WAIT: rst=1 at cycle 2 of an access -> next cycle state IDLE, outputs 0, stall_cycles=0, mem_err=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stall/flush
// generation, E-stage forwarding selects and the M-stage data-memory handshake.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_E,
    input  logic             reg_write_E,
    input  logic [1:0]       sel_wb_E,
    input  logic [4:0]       rd_M,
    input  logic             reg_write_M,
    input  logic [4:0]       rd_W,
    input  logic             reg_write_W,
    input  logic             pc_src_E,
    input  logic             mem_access_M,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_err
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    mem_state_e        state_r;
    mem_state_e        state_nxt_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_cnt_nxt_s;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic              mem_err_r;
    logic              req_s;
    logic              timeout_s;
    logic              mem_stall_s;
    logic              lu_s;

    // A writer in M is younger than W, so its value wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic rwm,
                                           input logic [4:0] rdw, input logic rww);
        logic [1:0] sel;
        if (rwm && (rdm != 5'd0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (rww && (rdw != 5'd0) && (rdw == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // State register, wait counter, stall statistics and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            wait_cnt_r     <= '0;
            stall_cycles_r <= '0;
            mem_err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (timeout_s) begin
                mem_err_r <= 1'b1;
            end
            if (stallF && (stall_cycles_r != {CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end
        end
    end

    // Hazard detection terms shared by next-state and output logic
    always_comb begin
        req_s       = ((state_r == IDLE) && mem_access_M) || (state_r == WAIT);
        timeout_s   = (state_r == WAIT) && (wait_cnt_r == WCNT_LAST) && !dmem_ack;
        mem_stall_s = req_s && !dmem_ack && !timeout_s;
        lu_s        = reg_write_E && (sel_wb_E == 2'b00) && (rd_E != 5'd0) &&
                      ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));
    end

    // Memory handshake next-state; an ack in the last wait cycle beats the timeout
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            IDLE: begin
                if (mem_access_M && !dmem_ack) begin
                    state_nxt_s    = WAIT;
                    wait_cnt_nxt_s = WCNT_W'(1);
                end else begin
                    state_nxt_s    = IDLE;
                    wait_cnt_nxt_s = '0;
                end
            end
            WAIT: begin
                if (dmem_ack || timeout_s) begin
                    state_nxt_s    = IDLE;
                    wait_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + WCNT_W'(1);
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                wait_cnt_nxt_s = '0;
            end
        endcase
    end

    // Stage controls: memory stall > taken branch > load-use
    always_comb begin
        dmem_req   = 1'b0;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushW     = 1'b0;
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
        if (rst) begin
            dmem_req = 1'b0;
        end else begin
            dmem_req   = req_s;
            forwardA_E = fwd_sel(rs1_addr_E, rd_M, reg_write_M, rd_W, reg_write_W);
            forwardB_E = fwd_sel(rs2_addr_E, rd_M, reg_write_M, rd_W, reg_write_W);
            if (mem_stall_s) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (pc_src_E) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lu_s) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else begin
                stallF = 1'b0;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign mem_err      = mem_err_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a combinational vector table plus
// hand-written sequences for the memory handshake, timeout, reset and saturation.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 8;
    localparam int CW  = 4;

    logic          clk;
    logic          rst;
    logic [4:0]    rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rd_W;
    logic          reg_write_E, reg_write_M, reg_write_W;
    logic [1:0]    sel_wb_E;
    logic          pc_src_E, mem_access_M, dmem_ack;
    logic          dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]    forwardA_E, forwardB_E;
    logic [CW-1:0] stall_cycles;
    logic          mem_err;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_E(rd_E), .reg_write_E(reg_write_E), .sel_wb_E(sel_wb_E),
        .rd_M(rd_M), .reg_write_M(reg_write_M),
        .rd_W(rd_W), .reg_write_W(reg_write_W),
        .pc_src_E(pc_src_E), .mem_access_M(mem_access_M), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .stall_cycles(stall_cycles), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde;
        logic        rwe;
        logic [1:0]  selwb;
        logic [4:0]  rdm;
        logic        rwm;
        logic [4:0]  rdw;
        logic        rww;
        logic        pcsrc, memacc, ack;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[18];

    // {dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdA, fwdB}
    function automatic logic [11:0] pk(input logic rq, input logic sf, input logic sd,
                                       input logic se, input logic sm, input logic fd,
                                       input logic fe, input logic fw,
                                       input logic [1:0] fa, input logic [1:0] fb);
        return {rq, sf, sd, se, sm, fd, fe, fw, fa, fb};
    endfunction

    function automatic logic [11:0] act_out();
        return {dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                forwardA_E, forwardB_E};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        rs1_addr_D = 5'd0; rs2_addr_D = 5'd0; rs1_addr_E = 5'd0; rs2_addr_E = 5'd0;
        rd_E = 5'd0; reg_write_E = 1'b0; sel_wb_E = 2'b11;
        rd_M = 5'd0; reg_write_M = 1'b0; rd_W = 5'd0; reg_write_W = 1'b0;
        pc_src_E = 1'b0; mem_access_M = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rs1_addr_D = v.rs1d; rs2_addr_D = v.rs2d; rs1_addr_E = v.rs1e; rs2_addr_E = v.rs2e;
        rd_E = v.rde; reg_write_E = v.rwe; sel_wb_E = v.selwb;
        rd_M = v.rdm; reg_write_M = v.rwm; rd_W = v.rdw; reg_write_W = v.rww;
        pc_src_E = v.pcsrc; mem_access_M = v.memacc; dmem_ack = v.ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_in();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_lu();
        reg_write_E = 1'b1; sel_wb_E = 2'b00; rd_E = 5'd5; rs1_addr_D = 5'd5;
    endtask

    initial begin
        logic [11:0] e_lu, e_br, e_ms;
        e_lu = pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        e_br = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        e_ms = pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);

        //          rs1d   rs2d   rs1e   rs2e   rde    rwe   selwb  rdm    rwm   rdw    rww   br    mem   ack
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e_lu};
        vecs[2]  = '{5'd1, 5'd5, 5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e_lu};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[4]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[5]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[6]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e_br};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e_br};
        vecs[8]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 2'b11, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 12'h008};
        vecs[9]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 2'b11, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 12'h004};
        vecs[10] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 2'b11, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 2'b11, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 12'h002};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 2'b11, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 12'h001};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 2'b11, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[14] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b11, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[15] = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 1'b0, 2'b11, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 12'h009};
        vecs[16] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h800};
        vecs[17] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h800 | e_lu};

        // reset: hazards and an access present while rst is held must all be masked
        rst = 1'b1;
        clear_in();
        set_lu();
        pc_src_E = 1'b1; mem_access_M = 1'b1;
        rs1_addr_E = 5'd7; rd_M = 5'd7; reg_write_M = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 32'(act_out()), 32'h0);
        chk("reset_stall_cycles", 32'(stall_cycles), 32'h0);
        chk("reset_mem_err", 32'(mem_err), 32'h0);
        do_reset();

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i), 32'(act_out()), 32'(vecs[i].exp));
            @(negedge clk);
        end

        // load-use counts exactly one stall cycle; rd_E=0 is not a hazard
        do_reset();
        set_lu();
        #1;
        chk("lu_out", 32'(act_out()), 32'(e_lu));
        @(negedge clk);
        rd_E = 5'd0; rs1_addr_D = 5'd0;
        #1;
        chk("lu_x0_out", 32'(act_out()), 32'h0);
        chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);

        // memory wait with ack on cycle 3; branch held off while stalled
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_in();
            mem_access_M = 1'b1;
            dmem_ack = (c == 3);
            pc_src_E = (c < 3);
            #1;
            chk($sformatf("wait_c%0d", c), 32'(act_out()),
                (c < 3) ? 32'(e_ms) : 32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00)));
            @(negedge clk);
        end
        clear_in();
        #1;
        chk("wait_after_req", 32'(dmem_req), 32'h0);
        chk("wait_stall_cycles", 32'(stall_cycles), 32'd3);

        // timeout: 8 request cycles, 7 stall cycles, sticky error
        do_reset();
        for (int c = 0; c < TMO; c++) begin
            mem_access_M = 1'b1;
            #1;
            chk($sformatf("tmo_req_c%0d", c), 32'(dmem_req), 32'h1);
            chk($sformatf("tmo_stall_c%0d", c), 32'(stallM), (c < TMO - 1) ? 32'h1 : 32'h0);
            chk($sformatf("tmo_err_c%0d", c), 32'(mem_err), 32'h0);
            @(negedge clk);
        end
        mem_access_M = 1'b0;
        #1;
        chk("tmo_req_after", 32'(dmem_req), 32'h0);
        chk("tmo_err_set", 32'(mem_err), 32'h1);
        chk("tmo_stall_cycles", 32'(stall_cycles), 32'd7);
        @(negedge clk);
        #1;
        chk("tmo_err_held", 32'(mem_err), 32'h1);

        // ack in the final wait cycle wins over the timeout
        do_reset();
        for (int c = 0; c < TMO; c++) begin
            mem_access_M = 1'b1;
            dmem_ack = (c == TMO - 1);
            #1;
            chk($sformatf("ack7_stall_c%0d", c), 32'(stallF), (c < TMO - 1) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        clear_in();
        #1;
        chk("ack7_err", 32'(mem_err), 32'h0);
        chk("ack7_req", 32'(dmem_req), 32'h0);

        // reset in the middle of a wait returns to IDLE
        do_reset();
        mem_access_M = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_during", 32'(act_out()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_access_M = 1'b0;
        #1;
        chk("rstw_after_out", 32'(act_out()), 32'h0);
        chk("rstw_stall_cycles", 32'(stall_cycles), 32'h0);
        chk("rstw_mem_err", 32'(mem_err), 32'h0);

        // stall counter saturates at all-ones
        do_reset();
        set_lu();
        repeat (14) @(negedge clk);
        #1;
        chk("sat_count14", 32'(stall_cycles), 32'd14);
        repeat (6) @(negedge clk);
        #1;
        chk("sat_count_max", 32'(stall_cycles), 32'd15);
        clear_in();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
